q3_muldiv: RTL
==============

# q3_muldiv

Iterative RV32M multiply/divide unit in the execute stage (q3). It consumes the operands and control latched by the decode-to-execute pipeline register, computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles, and raises a stall that freezes the PC, q1q2 and q2q3 until the result is ready. The result is muxed with the ALU result into q3q4 in the cycle `done_o` is high.

## Interface
- `XLEN`, 32: operand and result width; only 32 is supported.
- `clk`, input, 1: clock, rising-edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `valid_i`, input, 1: M-extension control bit from `ctrl_q2_o`; the instruction in q3 is a mul/div.
- `funct3_i`, input, 3: `instr_o[14:12]` of the q3 instruction.
- `rs1_i`, input, 32: `reg_rd_data1_o` (forwarded) operand A.
- `rs2_i`, input, 32: `reg_rd_data2_o` (forwarded) operand B.
- `flush_i`, input, 1: branch/trap flush of q3; aborts the operation.
- `stall_o`, output, 1: freeze PC, q1q2 and q2q3 this cycle.
- `done_o`, output, 1: `result_o` is valid this cycle; single-cycle pulse.
- `result_o`, output, 32: rd write-back value.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE**
  - On `valid_i & ~flush_i`, latch operands and `funct3_i`.
  - Take absolute values per signedness:
    - MULH, DIV, REM: both operands signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - MUL, MULHU, DIVU, REMU: both unsigned. MUL's low word is sign-agnostic.
  - Record the result sign:
    - mul: sign(A) XOR sign(B).
    - DIV: sign(A) XOR sign(B).
    - REM: sign(A).
  - Clear the 6-bit counter and go to CALC.
- **Fast paths from IDLE go directly to DONE:**
  - Divide by zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result rs1.
  - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): DIV result 0x80000000, REM result 0.
- **CALC**, one iteration per cycle, 32 iterations (count 0..31):
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract; 32-bit quotient plus 33-bit partial remainder.
  - At count==31, go to DONE.
- **DONE**
  - Apply two's-complement sign correction. Multiplies negate the full 64-bit product before selecting the word.
  - Word selection: MUL takes bits [31:0]; MULH/MULHSU/MULHU take bits [63:32].
  - Register `result_o`, drive `done_o=1`, then go to IDLE next edge.
- **`stall_o`** = `valid_i & ~flush_i & (state != DONE)`. It is combinational, so it is high in the IDLE cycle that starts an operation.
- **Flush**
  - `flush_i` in any state forces IDLE next edge; `done_o` is never raised for the aborted op.
  - `flush_i` together with `valid_i` in IDLE: flush wins and nothing starts.
- **`valid_i` falling in CALC** (no flush): treated as an abort, go to IDLE.
- **Back-to-back M instructions:** the DONE-cycle edge advances q2q3. The next cycle sees the new instruction in IDLE and starts normally; there are no idle bubbles beyond the IDLE start cycle.

## Timing
- **Reset values:** state IDLE, counter 0, `done_o`=0, `result_o`=0. `stall_o`=0 during reset because q2q3 presents a NOP with ctrl=0.
- **Normal op:**
  - Cycle 0: IDLE, `stall_o`=1.
  - Cycles 1–32: CALC, `stall_o`=1.
  - Cycle 33: DONE, `stall_o`=0, `done_o`=1.
  - Total q3 occupancy is 34 cycles.
- **Fast path:** cycle 0 IDLE (stall), cycle 1 DONE; total 2 cycles.
- **Reset mid-operation:** asserting reset returns the unit to reset values asynchronously; no partial result is emitted.
- Operand registers are held constant from capture to DONE. Changes on `rs1_i`/`rs2_i` after cycle 0 have no effect.

## Structure
- Shared header `riscv_defs.vh` holds:
  - funct3 localparams: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - The M-extension ctrl bit index within `ctrl_q2`.
- State encoding stays local to the module.
- A single module is sufficient; no sub-module. The abs/negate helpers are local functions.
- Top-level integration: OR `stall_o` into the existing hazard-stall net, and select `result_o` over the ALU output when `done_o`.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD -> `result_o`=0xFFFFFFEB, `done_o` in cycle 33, `stall_o` high in cycles 0–32.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 10/0 -> 0xFFFFFFFF and REMU 10/0 -> 10, both with `done_o` in cycle 1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM same -> 0, both in cycle 1.
- Flush in cycle 10 of a DIV -> `stall_o`=0 in cycle 11, `done_o` never asserts. A following MUL 3×4 then returns 12 after 34 cycles.
- `rst_n` low in cycle 20 of a MUL -> state IDLE, `done_o`=0, `result_o`=0 immediately. Back-to-back MUL 2×3 then MUL 5×5 -> 6 in cycle 33, then 25 in cycle 67.

Source files
------------

// File: rtl/q3_muldiv_pkg.sv
// Shared constants for the q3 RV32M multiply/divide unit: funct3 decode
// values and the iteration count of the shift-add / shift-subtract loop.
package q3_muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // one result bit per cycle, so 32 iterations for RV32
    localparam int MD_ITERS = 32;

endpackage

// File: rtl/q3_muldiv_if.sv
// Execute-stage handshake between the q2q3 pipeline register (master) and
// the multiply/divide unit (slave).
interface q3_muldiv_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            flush_i;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output valid_i, funct3_i, rs1_i, rs2_i, flush_i,
        input  stall_o, done_o, result_o
    );

    modport slave (
        input  valid_i, funct3_i, rs1_i, rs2_i, flush_i,
        output stall_o, done_o, result_o
    );
endinterface

// File: rtl/q3_muldiv.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes at
// start, a 32-step shift-add (multiply) or restoring shift-subtract (divide)
// runs in CALC, and the sign is re-applied on the way into the DONE cycle.
// Divide-by-zero and signed overflow bypass the loop.
module q3_muldiv
    import q3_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    q3_muldiv_if.slave md
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [5:0]      CNT_LAST = 6'(MD_ITERS - 1);

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
        return ~v + 1'b1;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_d(input logic [2*XLEN-1:0] v);
        return ~v + 1'b1;
    endfunction

    logic [1:0]        state;
    logic [5:0]        cnt;
    logic [2:0]        f3;
    logic              neg;
    logic [XLEN-1:0]   opnd;     // |A| multiplicand or |B| divisor
    logic [2*XLEN-1:0] acc;      // mul: product/multiplier, div: [XLEN-1:0] dividend->quotient
    logic [XLEN:0]     rem;      // divide partial remainder
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    logic              start, is_div, a_sgn, b_sgn, a_neg, b_neg, res_neg, fast;
    logic [XLEN-1:0]   a_abs, b_abs, fast_res;

    logic [XLEN:0]     mul_sum;
    logic [XLEN+1:0]   rem_sh, div_diff;
    logic [2*XLEN-1:0] acc_nx, prod;
    logic [XLEN:0]     rem_nx;
    logic [XLEN-1:0]   quo, remv, res_fin;

    assign start      = md.valid_i & ~md.flush_i;
    assign md.stall_o = start & (state != S_DONE);
    assign md.done_o  = done_q;
    assign md.result_o = result_q;

    // start-cycle decode: signedness, magnitudes, result sign and fast paths
    always_comb begin
        is_div  = md.funct3_i[2];
        a_sgn   = (md.funct3_i == F3_MULH) || (md.funct3_i == F3_MULHSU) ||
                  (md.funct3_i == F3_DIV)  || (md.funct3_i == F3_REM);
        b_sgn   = (md.funct3_i == F3_MULH) || (md.funct3_i == F3_DIV) ||
                  (md.funct3_i == F3_REM);
        a_neg   = a_sgn & md.rs1_i[XLEN-1];
        b_neg   = b_sgn & md.rs2_i[XLEN-1];
        a_abs   = abs_val(md.rs1_i, a_sgn);
        b_abs   = abs_val(md.rs2_i, b_sgn);
        // remainder follows the dividend; quotient and product use XOR
        res_neg = (is_div && md.funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
        fast     = 1'b0;
        fast_res = '0;
        if (is_div && (md.rs2_i == '0)) begin
            fast     = 1'b1;
            fast_res = md.funct3_i[1] ? md.rs1_i : '1;
        end else if (is_div && b_sgn && (md.rs1_i == INT_MIN) && (md.rs2_i == '1)) begin
            fast     = 1'b1;
            fast_res = md.funct3_i[1] ? '0 : INT_MIN;
        end
    end

    // one loop iteration: shift-add for multiply, restoring subtract for divide
    always_comb begin
        mul_sum  = '0;
        rem_sh   = '0;
        div_diff = '0;
        acc_nx   = acc;
        rem_nx   = rem;
        if (!f3[2]) begin
            mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
            acc_nx  = {mul_sum, acc[XLEN-1:1]};
        end else begin
            rem_sh   = {rem, acc[XLEN-1]};
            div_diff = rem_sh - {2'b00, opnd};
            if (!div_diff[XLEN+1]) begin
                rem_nx = div_diff[XLEN:0];
                acc_nx = {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], 1'b1};
            end else begin
                rem_nx = rem_sh[XLEN:0];
                acc_nx = {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], 1'b0};
            end
        end
    end

    // sign correction and word select, taken from the final iteration's output
    always_comb begin
        prod    = neg ? neg_d(acc_nx) : acc_nx;
        quo     = neg ? neg_w(acc_nx[XLEN-1:0]) : acc_nx[XLEN-1:0];
        remv    = neg ? neg_w(rem_nx[XLEN-1:0]) : rem_nx[XLEN-1:0];
        if (!f3[2])
            res_fin = (f3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else
            res_fin = f3[1] ? remv : quo;
    end

    // control FSM plus datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            f3       <= '0;
            neg      <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            rem      <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        f3  <= md.funct3_i;
                        neg <= res_neg;
                        cnt <= '0;
                        if (fast) begin
                            result_q <= fast_res;
                            done_q   <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            opnd  <= is_div ? b_abs : a_abs;
                            acc   <= {{XLEN{1'b0}}, (is_div ? a_abs : b_abs)};
                            rem   <= '0;
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    // a flush or the instruction leaving q3 abandons the op
                    if (md.flush_i || !md.valid_i) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= acc_nx;
                        rem <= rem_nx;
                        cnt <= cnt + 6'd1;
                        if (cnt == CNT_LAST) begin
                            result_q <= res_fin;
                            done_q   <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
